// File: rtl/dump_pkg.sv
// Shared definitions for the memory dump engine: FSM encoding, region IDs
// and the width of the {region, index, last} tag that travels with each read.
package dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic REGION_INSN = 1'b0;
  localparam logic REGION_DATA = 1'b1;

  function automatic int tag_width(input int addr_w);
    return 1 + addr_w + 1;
  endfunction

endpackage

// File: rtl/dump_fifo.sv
// Synchronous FIFO holding {data, tag} words on their way to the dump stream.
// The head entry is read straight from storage; flush empties it in one cycle.
module dump_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (push) store[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = store[rd_ptr];

endmodule

// File: rtl/mem_dump_engine.sv
// Halts the core and streams region 0 then region 1 memory contents over a
// valid/ready port, issuing reads only when the output FIFO has room for them.
module mem_dump_engine
  import dump_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4,
  parameter int R0_WORDS   = 64,
  parameter int R1_WORDS   = 256,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger,
  input  logic              abort,
  input  logic              release_dump,
  output logic              halt_req,
  output logic              mem_ren,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_region,
  output logic              dump_last,
  output logic              done,
  output logic [1:0]        fsm_state
);

  localparam int TAG_W = tag_width(ADDR_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CW    = CNT_W + 1;
  localparam logic FIRST_REGION = (R0_WORDS != 0) ? REGION_INSN : REGION_DATA;
  localparam logic LAST_REGION  = (R1_WORDS != 0) ? REGION_DATA : REGION_INSN;
  localparam logic [ADDR_W-1:0] R0_END = ADDR_W'(R0_WORDS - 1);
  localparam logic [ADDR_W-1:0] R1_END = ADDR_W'(R1_WORDS - 1);
  localparam bit NO_WORDS = (R0_WORDS == 0) && (R1_WORDS == 0);

  // Handshake: a stream word transfers on any rising edge where dump_valid and
  // dump_ready are both 1; while valid is 1 and ready is 0 the dump_* outputs hold.

  state_t             state;
  logic               trig_q;
  logic               region;
  logic [ADDR_W-1:0]  index;
  logic [TAG_W-1:0]   issue_tag;
  logic [TAG_W:0]     tag_pipe [RD_LAT];
  logic [CNT_W-1:0]   fifo_count;
  logic [DATA_W+TAG_W-1:0] fifo_head;

  logic [ADDR_W-1:0]  region_end;
  logic [ADDR_W-1:0]  next_index;
  logic               next_region;
  logic               cur_last;
  logic [CW-1:0]      used;
  logic               pipe_busy;
  logic               can_issue;
  logic               trig_edge;
  logic               issue;
  logic               flush;
  logic               pop;
  logic               drained;

  assign pop       = dump_valid && dump_ready;
  assign trig_edge = trigger && !trig_q;
  assign flush     = abort && (state != ST_IDLE);

  // used = FIFO entries plus reads still in flight, after this cycle's pop.
  always_comb begin
    region_end  = region ? R1_END : R0_END;
    cur_last    = (region == LAST_REGION) && (index == region_end);
    next_region = region;
    next_index  = index + ADDR_W'(1);
    if (index == region_end) begin
      next_region = LAST_REGION;
      next_index  = '0;
    end
    used      = CW'(fifo_count) + CW'(mem_ren);
    pipe_busy = mem_ren;
    for (int k = 0; k < RD_LAT; k++) begin
      used      = used + CW'(tag_pipe[k][TAG_W]);
      pipe_busy = pipe_busy | tag_pipe[k][TAG_W];
    end
    used      = used - CW'(pop);
    can_issue = (used < CW'(FIFO_DEPTH));
    drained   = !pipe_busy && (fifo_count == CNT_W'(pop));
    issue     = !abort && (((state == ST_IDLE) && trig_edge && !NO_WORDS) ||
                           ((state == ST_RUN) && can_issue));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      trig_q    <= 1'b0;
      region    <= FIRST_REGION;
      index     <= '0;
      mem_ren   <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      issue_tag <= '0;
      halt_req  <= 1'b0;
      done      <= 1'b0;
    end else begin
      trig_q  <= trigger;
      done    <= 1'b0;
      mem_ren <= issue;
      if (issue) begin
        mem_sel   <= region;
        mem_addr  <= index * ADDR_W'(WORD_BYTES);
        issue_tag <= {region, index, cur_last};
        region    <= next_region;
        index     <= next_index;
      end
      if (flush) begin
        state    <= ST_IDLE;
        halt_req <= 1'b0;
        region   <= FIRST_REGION;
        index    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (trig_edge && !abort) begin
              halt_req <= 1'b1;
              if (NO_WORDS) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= cur_last ? ST_DRAIN : ST_RUN;
              end
            end
          end
          ST_RUN:   if (issue && cur_last) state <= ST_DRAIN;
          ST_DRAIN: begin
            if (drained) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
          ST_DONE: begin
            if (release_dump) begin
              state    <= ST_IDLE;
              halt_req <= 1'b0;
              region   <= FIRST_REGION;
              index    <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Stage k holds the tag of the read issued k+1 cycles before mem_ren's cycle.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int k = 0; k < RD_LAT; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0] <= {mem_ren, issue_tag};
      for (int k = 1; k < RD_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  dump_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + TAG_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (tag_pipe[RD_LAT-1][TAG_W]),
    .pop   (pop),
    .wdata ({mem_rdata, tag_pipe[RD_LAT-1][TAG_W-1:0]}),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign dump_valid = (fifo_count != '0);
  assign {dump_data, dump_region, dump_index, dump_last} = dump_valid ? fifo_head : '0;
  assign fsm_state  = state;

endmodule

// File: tb/tb_mem_dump_engine.sv
// Bench for mem_dump_engine: a default-parameter instance and a small
// region-1-only instance with three-cycle memory latency.
module tb_mem_dump_engine;
  import dump_pkg::*;

  localparam int A_R0 = 64, A_R1 = 256, A_DEPTH = 4;
  localparam int B_R1 = 6, B_DEPTH = 4;
  localparam int SBW = 66;
  typedef logic [SBW-1:0] sb_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input sb_t got, input sb_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- instance A (defaults) ----------------
  logic trigger_a = 0, abort_a = 0, release_a = 0, ready_a = 0;
  logic halt_a, ren_a, sel_a, valid_a, region_a, last_a, done_a;
  logic [31:0] addr_a, rdata_a, data_a, index_a;
  logic [1:0] state_a;
  logic [31:0] imem [A_R0];
  logic [31:0] dmem [A_R1];

  mem_dump_engine u_a (
    .clock(clock), .reset(reset), .trigger(trigger_a), .abort(abort_a),
    .release_dump(release_a), .halt_req(halt_a), .mem_ren(ren_a),
    .mem_sel(sel_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .dump_valid(valid_a), .dump_ready(ready_a), .dump_data(data_a),
    .dump_index(index_a), .dump_region(region_a), .dump_last(last_a),
    .done(done_a), .fsm_state(state_a)
  );

  always @(posedge clock)
    rdata_a <= ren_a ? (sel_a ? dmem[addr_a[9:2]] : imem[addr_a[7:2]]) : $urandom;

  // ---------------- instance B (R0=0, R1=6, RD_LAT=3) ----------------
  logic trigger_b = 0, abort_b = 0, release_b = 0, ready_b = 0;
  logic halt_b, ren_b, sel_b, valid_b, region_b, last_b, done_b;
  logic [31:0] addr_b, rdata_b, data_b, index_b;
  logic [1:0] state_b;
  logic [31:0] dmem_b [8];
  logic [31:0] rd_b [3];

  mem_dump_engine #(.R0_WORDS(0), .R1_WORDS(B_R1), .RD_LAT(3), .FIFO_DEPTH(B_DEPTH)) u_b (
    .clock(clock), .reset(reset), .trigger(trigger_b), .abort(abort_b),
    .release_dump(release_b), .halt_req(halt_b), .mem_ren(ren_b),
    .mem_sel(sel_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .dump_valid(valid_b), .dump_ready(ready_b), .dump_data(data_b),
    .dump_index(index_b), .dump_region(region_b), .dump_last(last_b),
    .done(done_b), .fsm_state(state_b)
  );

  always @(posedge clock) begin
    rd_b[0] <= ren_b ? dmem_b[addr_b[4:2]] : $urandom;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign rdata_b = rd_b[2];

  // ---------------- scoreboards ----------------
  logic [SBW-1:0] exp_q[$];   // A stream: {region, index, last, data}
  logic [SBW-1:0] rd_q[$];    // A reads: {sel, addr}
  logic [SBW-1:0] exp_b_q[$];
  logic [SBW-1:0] rd_b_q[$];
  int iss_a = 0, acc_a = 0, done_n_a = 0, done_cyc_a = 0, first_valid_a = -1;
  int iss_b = 0, acc_b = 0, done_n_b = 0;

  // Reference: every word of region 0 then region 1, last flag on the final one.
  task automatic build_a();
    exp_q.delete(); rd_q.delete();
    iss_a = 0; acc_a = 0; first_valid_a = -1;
    for (int i = 0; i < A_R0; i++) begin
      exp_q.push_back({1'b0, 32'(i), 1'b0, imem[i]});
      rd_q.push_back(sb_t'({1'b0, 32'(i * 4)}));
    end
    for (int i = 0; i < A_R1; i++) begin
      exp_q.push_back({1'b1, 32'(i), 1'(i == A_R1 - 1), dmem[i]});
      rd_q.push_back(sb_t'({1'b1, 32'(i * 4)}));
    end
  endtask

  task automatic build_b();
    exp_b_q.delete(); rd_b_q.delete();
    iss_b = 0; acc_b = 0;
    for (int i = 0; i < B_R1; i++) begin
      exp_b_q.push_back({1'b1, 32'(i), 1'(i == B_R1 - 1), dmem_b[i]});
      rd_b_q.push_back(sb_t'({1'b1, 32'(i * 4)}));
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (ren_a) begin
        iss_a++;
        check("a_credit", sb_t'(iss_a - acc_a <= A_DEPTH), sb_t'(1));
        if (rd_q.size() == 0) check("a_read_spurious", sb_t'(1), sb_t'(0));
        else check("a_read_addr", sb_t'({sel_a, addr_a}), rd_q.pop_front());
      end
      if (valid_a && first_valid_a < 0) first_valid_a = cyc;
      if (valid_a && ready_a) begin
        acc_a++;
        if (exp_q.size() == 0) check("a_word_spurious", sb_t'(1), sb_t'(0));
        else check("a_word", {region_a, index_a, last_a, data_a}, exp_q.pop_front());
      end
      if (done_a) begin done_n_a++; done_cyc_a = cyc; end
      if (ren_b) begin
        iss_b++;
        check("b_credit", sb_t'(iss_b - acc_b <= B_DEPTH), sb_t'(1));
        if (rd_b_q.size() == 0) check("b_read_spurious", sb_t'(1), sb_t'(0));
        else check("b_read_addr", sb_t'({sel_b, addr_b}), rd_b_q.pop_front());
      end
      if (valid_b && ready_b) begin
        acc_b++;
        if (exp_b_q.size() == 0) check("b_word_spurious", sb_t'(1), sb_t'(0));
        else check("b_word", {region_b, index_b, last_b, data_b}, exp_b_q.pop_front());
      end
      if (done_b) done_n_b++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic trig_a(output int t);
    tick(); trigger_a = 1; t = cyc;
    tick(); trigger_a = 0;
  endtask

  task automatic pulse_release_a();
    tick(); release_a = 1;
    tick(); release_a = 0;
  endtask

  // Random ready (30% high) when rnd is set; a stray trigger is raised mid-run.
  task automatic wait_done_a(input int budget, input bit rnd, input int n0);
    int k;
    k = 0;
    while (done_n_a == n0 && k < budget) begin
      tick(); k++;
      if (rnd) ready_a = ($urandom_range(0, 99) < 30);
      if (rnd) trigger_a = (k >= 40 && k < 44);
    end
    trigger_a = 0;
    check("a_done_seen", sb_t'(done_n_a), sb_t'(n0 + 1));
  endtask

  task automatic wait_acc_a(input int target, input int budget);
    int k;
    k = 0;
    while (acc_a < target && k < budget) begin tick(); k++; end
    check("a_acc_reached", sb_t'(acc_a >= target), sb_t'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, n0, k;
    for (int i = 0; i < A_R0; i++) imem[i] = $urandom;
    for (int i = 0; i < A_R1; i++) dmem[i] = $urandom;
    for (int i = 0; i < 8; i++) dmem_b[i] = $urandom;
    repeat (3) tick();
    check("a_reset_ctrl", sb_t'({halt_a, ren_a, sel_a, valid_a, done_a, state_a}), sb_t'(0));
    reset = 0;
    tick();
    check("a_idle_outs", sb_t'({halt_a, ren_a, valid_a, addr_a, data_a}), sb_t'(0));
    check("b_idle_outs", sb_t'({halt_b, ren_b, valid_b, addr_b, data_b}), sb_t'(0));

    // Full dump with ready held high.
    build_a(); ready_a = 1; n0 = done_n_a;
    trig_a(t0);
    check("a_halt_start", sb_t'(halt_a), sb_t'(1));
    check("a_first_ren", sb_t'(ren_a), sb_t'(1));
    wait_done_a(600, 0, n0);
    check("a_done_latency", sb_t'(done_cyc_a - t0), sb_t'(A_R0 + A_R1 + 1 + 2));
    check("a_first_valid", sb_t'(first_valid_a - t0), sb_t'(3));
    check("a_words_left", sb_t'(exp_q.size() + rd_q.size()), sb_t'(0));
    tick();
    check("a_halt_in_done", sb_t'({halt_a, valid_a}), sb_t'(2'b10));
    pulse_release_a();
    check("a_release_halt", sb_t'(halt_a), sb_t'(0));
    check("a_done_once", sb_t'(done_n_a), sb_t'(n0 + 1));

    // Random back-pressure; abort + release together in DONE.
    build_a(); n0 = done_n_a;
    trig_a(t0);
    wait_done_a(4000, 1, n0);
    ready_a = 1;
    check("a_rand_words_left", sb_t'(exp_q.size() + rd_q.size()), sb_t'(0));
    tick(); abort_a = 1; release_a = 1;
    tick(); abort_a = 0; release_a = 0;
    check("a_abort_rel", sb_t'({halt_a, state_a}), sb_t'({1'b0, ST_IDLE}));
    check("a_abort_rel_done", sb_t'(done_n_a), sb_t'(n0 + 1));

    // Abort mid-run around word 100, then restart from the beginning.
    build_a(); n0 = done_n_a;
    trig_a(t0);
    wait_acc_a(100, 400);
    abort_a = 1;
    tick(); abort_a = 0;
    check("a_abort_outs", sb_t'({halt_a, valid_a, ren_a, state_a}), sb_t'(0));
    exp_q.delete(); rd_q.delete();
    repeat (30) tick();
    check("a_abort_no_done", sb_t'(done_n_a), sb_t'(n0));
    check("a_abort_quiet", sb_t'({valid_a, ren_a, halt_a}), sb_t'(0));
    build_a();
    trig_a(t0);
    wait_done_a(600, 0, n0);
    check("a_retrig_latency", sb_t'(done_cyc_a - t0), sb_t'(A_R0 + A_R1 + 3));
    check("a_retrig_left", sb_t'(exp_q.size()), sb_t'(0));
    pulse_release_a();

    // Reset while draining.
    build_a(); n0 = done_n_a;
    trig_a(t0);
    k = 0;
    while (iss_a < A_R0 + A_R1 && k < 600) begin tick(); k++; end
    ready_a = 0;
    repeat (3) tick();
    check("a_in_drain", sb_t'(state_a), sb_t'(ST_DRAIN));
    reset = 1;
    tick();
    check("a_rst_ctrl", sb_t'({halt_a, ren_a, sel_a, valid_a, region_a, last_a, done_a, state_a}), sb_t'(0));
    check("a_rst_addr", sb_t'({addr_a, index_a}), sb_t'(0));
    check("a_rst_data", sb_t'(data_a), sb_t'(0));
    reset = 0; ready_a = 1;
    exp_q.delete(); rd_q.delete();
    repeat (5) tick();
    check("a_rst_no_done", sb_t'(done_n_a), sb_t'(n0));

    // Instance B: region 1 only, stalled consumer, latency 3.
    build_b(); n0 = done_n_b;
    tick(); trigger_b = 1;
    tick(); trigger_b = 0;
    repeat (19) tick();
    check("b_stall_reads", sb_t'(iss_b), sb_t'(B_DEPTH));
    check("b_stall_words", sb_t'(acc_b), sb_t'(0));
    ready_b = 1;
    k = 0;
    while (done_n_b == n0 && k < 100) begin tick(); k++; end
    check("b_done_seen", sb_t'(done_n_b), sb_t'(n0 + 1));
    check("b_words_left", sb_t'(exp_b_q.size() + rd_b_q.size()), sb_t'(0));
    check("b_halt_in_done", sb_t'(halt_b), sb_t'(1));
    tick(); release_b = 1;
    tick(); release_b = 0;
    check("b_release_halt", sb_t'(halt_b), sb_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
